cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) among the execution units: div, mul, int and ls.
- Each unit pushes completed results (tag + data) into a small per-unit result buffer through a valid/ready handshake.
- A round-robin arbiter picks one buffered result per cycle and drives the registered CDB broadcast.
- It sits between the execution-unit outputs and the reservation stations / register file.
- It absorbs collisions that the issue-time slot reservation does not prevent, such as flush recovery and variable-latency units.

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_result_fifo.sv | 87 ++++++++
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter slice.
package cdb_pkg;

   localparam int CDB_NUM_UNITS = 4;
   localparam int CDB_DATA_W    = 32;
   localparam int CDB_TAG_W     = 6;
   localparam int CDB_BUF_DEPTH = 2;

   localparam int UNIT_DIV = 0;
   localparam int UNIT_MUL = 1;
   localparam int UNIT_INT = 2;
   localparam int UNIT_LS  = 3;

   typedef logic [$clog2(CDB_NUM_UNITS)-1:0] unit_idx_t;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-unit result buffer: small FIFO whose ready depends only on the
// registered occupancy; clear wins over any push or pop in the same cycle.
module cdb_result_fifo
   import cdb_pkg::*;
#(
   parameter int  DEPTH   = CDB_BUF_DEPTH,
   parameter type entry_t = cdb_entry_t
) (
   input  logic   clk,
   input  logic   rst_b,
   input  logic   clear,
   input  logic   push,
   input  entry_t push_entry,
   input  logic   pop,
   output logic   ready,
   output logic   not_empty,
   output entry_t head
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           mem_q [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign ready     = (count_q != CNT_W'(DEPTH));
   assign not_empty = (count_q != CNT_W'(0));
   assign head      = mem_q[rd_ptr_q];
   assign do_push_s = push & ready;
   assign do_pop_s  = pop & not_empty;

   // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_s && !clear) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-unit result FIFOs feeding a round-robin grant and a
// registered single-result broadcast onto the common data bus.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_UNITS = CDB_NUM_UNITS,
   parameter int DATA_W    = CDB_DATA_W,
   parameter int TAG_W     = CDB_TAG_W,
   parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic [NUM_UNITS-1:0]         res_valid,
   output logic [NUM_UNITS-1:0]         res_ready,
   input  logic [NUM_UNITS*DATA_W-1:0]  res_data,
   input  logic [NUM_UNITS*TAG_W-1:0]   res_tag,
   input  logic                         flush,
   output logic                         cdb_valid,
   output logic [TAG_W-1:0]             cdb_tag,
   output logic [DATA_W-1:0]            cdb_data,
   output logic [$clog2(NUM_UNITS)-1:0] cdb_src
);
   localparam int SRC_W = $clog2(NUM_UNITS);

   logic                 live_q;
   logic [NUM_UNITS-1:0] fifo_ready_s;
   logic [NUM_UNITS-1:0] req_s;
   logic [NUM_UNITS-1:0] push_s;
   logic [NUM_UNITS-1:0] pop_s;
   cdb_entry_t           head_s [NUM_UNITS];

   logic                 gnt_valid_s;
   logic [SRC_W-1:0]     gnt_idx_s;
   logic [SRC_W-1:0]     scan_s;
   logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic                 cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
   logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;

   // Keeps res_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
      end
   end

   assign res_ready = fifo_ready_s & {NUM_UNITS{live_q}};
   assign push_s    = res_valid & res_ready;

   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      cdb_entry_t push_entry_s;
      assign push_entry_s.tag  = res_tag[gi*TAG_W +: TAG_W];
      assign push_entry_s.data = res_data[gi*DATA_W +: DATA_W];

      cdb_result_fifo #(
         .DEPTH   (BUF_DEPTH),
         .entry_t (cdb_entry_t)
      ) u_fifo (
         .clk        (clk),
         .rst_b      (rst_b),
         .clear      (flush),
         .push       (push_s[gi]),
         .push_entry (push_entry_s),
         .pop        (pop_s[gi]),
         .ready      (fifo_ready_s[gi]),
         .not_empty  (req_s[gi]),
         .head       (head_s[gi])
      );
   end

   // Round-robin scan starting at rr_ptr; a flush suppresses the pop.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = '0;
      scan_s      = '0;
      pop_s       = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         scan_s = SRC_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
         if (!gnt_valid_s && req_s[scan_s]) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = scan_s;
         end else begin
            gnt_valid_s = gnt_valid_s;
         end
      end
      pop_s[gnt_idx_s] = gnt_valid_s & ~flush;
   end

   // Pointer advance and broadcast staging; tag/data/src hold when idle.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      if (gnt_valid_s && !flush) begin
         rr_ptr_d    = (gnt_idx_s == SRC_W'(NUM_UNITS - 1)) ? SRC_W'(0) : gnt_idx_s + SRC_W'(1);
         cdb_valid_d = 1'b1;
         cdb_tag_d   = head_s[gnt_idx_s].tag;
         cdb_data_d  = head_s[gnt_idx_s].data;
         cdb_src_d   = gnt_idx_s;
      end else begin
         cdb_valid_d = 1'b0;
      end
   end

   // Arbiter pointer and broadcast output registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic         clk = 1'b0;
   logic         rst_b;
   logic [3:0]   res_valid;
   logic [3:0]   res_ready;
   logic [127:0] res_data;
   logic [23:0]  res_tag;
   logic         flush;
   logic         cdb_valid;
   logic [5:0]   cdb_tag;
   logic [31:0]  cdb_data;
   unit_idx_t    cdb_src;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one queue of {tag,data} per unit plus the broadcast register.
   logic [37:0] mq [4][$];
   int          m_rr;
   logic        m_live;
   logic        m_valid;
   logic [5:0]  m_tag;
   logic [31:0] m_data;
   logic [1:0]  m_src;
   logic [3:0]  last_acc;
   int          src_log[$];
   logic [5:0]  tag_log[$];

   typedef struct {
      logic [3:0] valid;
      logic [5:0] tbase;
      logic [3:0] exp_ready;
      logic       exp_valid;
      logic [5:0] exp_tag;
      logic [1:0] exp_src;
   } vec_t;
   vec_t tbl[13];

   function automatic logic [31:0] mkdata(input logic [5:0] t);
      if (t == 6'h05) return 32'hA5A5A5A5;
      return {2'b10, t, 2'b01, t, 2'b11, t, 2'b00, t};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_rr = 0; m_live = 1'b0; m_valid = 1'b0;
      m_tag = 6'h00; m_data = 32'h0; m_src = 2'd0; last_acc = 4'h0;
   endtask

   function automatic bit busy();
      bit b = m_valid;
      for (int i = 0; i < 4; i++) if (mq[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic set(input int u, input logic [5:0] t, input logic [31:0] d);
      res_valid[u]       = 1'b1;
      res_tag[u*6 +: 6]  = t;
      res_data[u*32 +: 32] = d;
   endtask

   // Check current outputs against the model, then advance one clock.
   task automatic tick();
      logic [3:0] rdy;
      logic [3:0] acc;
      bit         found;
      for (int i = 0; i < 4; i++) rdy[i] = m_live && (mq[i].size() < 2);
      chk("ready_model", 64'(res_ready), 64'(rdy));
      chk("cdb_model", 64'({cdb_valid, cdb_tag, cdb_data, cdb_src}),
          64'({m_valid, m_tag, m_data, m_src}));
      if (cdb_valid) begin
         src_log.push_back(int'(cdb_src));
         tag_log.push_back(cdb_tag);
      end
      @(posedge clk);
      acc = res_valid & rdy;
      if (flush) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
         m_valid = 1'b0;
      end else begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            int u = (m_rr + k) % 4;
            if (!found && mq[u].size() > 0) begin
               logic [37:0] e = mq[u].pop_front();
               found  = 1'b1;
               m_tag  = e[37:32];
               m_data = e[31:0];
               m_src  = 2'(u);
               m_rr   = (u + 1) % 4;
            end
         end
         m_valid = found;
         for (int i = 0; i < 4; i++)
            if (acc[i]) mq[i].push_back({res_tag[i*6 +: 6], res_data[i*32 +: 32]});
      end
      m_live   = 1'b1;
      last_acc = acc;
      #1;
   endtask

   task automatic step();
      tick();
      res_valid = res_valid & ~last_acc;
   endtask

   task automatic drain();
      int k = 0;
      res_valid = 4'h0;
      while (k < 40 && busy()) begin
         step();
         k++;
      end
      chk("drain_done", 64'(busy()), 64'(0));
   endtask

   initial begin
      int exp_src_a[5] = '{0, 1, 0, 1, 1};
      int exp_tag_a[5] = '{32'h20, 32'h28, 32'h21, 32'h29, 32'h2A};

      tbl[0]  = '{4'b0000, 6'h00, 4'b0000, 1'b0, 6'h00, 2'd0};
      tbl[1]  = '{4'b0100, 6'h03, 4'b1111, 1'b0, 6'h00, 2'd0};
      tbl[2]  = '{4'b0000, 6'h00, 4'b1111, 1'b0, 6'h00, 2'd0};
      tbl[3]  = '{4'b0000, 6'h00, 4'b1111, 1'b1, 6'h05, 2'd2};
      tbl[4]  = '{4'b1000, 6'h04, 4'b1111, 1'b0, 6'h05, 2'd2};
      tbl[5]  = '{4'b0000, 6'h00, 4'b1111, 1'b0, 6'h05, 2'd2};
      tbl[6]  = '{4'b1111, 6'h10, 4'b1111, 1'b1, 6'h07, 2'd3};
      tbl[7]  = '{4'b0000, 6'h00, 4'b1111, 1'b0, 6'h07, 2'd3};
      tbl[8]  = '{4'b0000, 6'h00, 4'b1111, 1'b1, 6'h10, 2'd0};
      tbl[9]  = '{4'b0000, 6'h00, 4'b1111, 1'b1, 6'h11, 2'd1};
      tbl[10] = '{4'b0000, 6'h00, 4'b1111, 1'b1, 6'h12, 2'd2};
      tbl[11] = '{4'b0000, 6'h00, 4'b1111, 1'b1, 6'h13, 2'd3};
      tbl[12] = '{4'b0000, 6'h00, 4'b1111, 1'b0, 6'h13, 2'd3};

      rst_b = 1'b0; res_valid = 4'h0; res_data = '0; res_tag = '0; flush = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset_ready", 64'(res_ready), 64'(0));
      chk("in_reset_cdb_valid", 64'(cdb_valid), 64'(0));
      rst_b = 1'b1;

      // Directed table: single push latency, then four-way simultaneous push.
      for (int r = 0; r < 13; r++) begin
         for (int u = 0; u < 4; u++)
            if (tbl[r].valid[u]) set(u, tbl[r].tbase + 6'(u), mkdata(tbl[r].tbase + 6'(u)));
         chk($sformatf("tbl%0d_ready", r), 64'(res_ready), 64'(tbl[r].exp_ready));
         chk($sformatf("tbl%0d_cdb", r), 64'({cdb_valid, cdb_tag, cdb_data, cdb_src}),
             64'({tbl[r].exp_valid, tbl[r].exp_tag,
                  (tbl[r].exp_tag == 6'h00) ? 32'h0 : mkdata(tbl[r].exp_tag), tbl[r].exp_src}));
         step();
      end

      // Unit 1 pushes three back-to-back while unit 0 keeps two queued.
      src_log.delete(); tag_log.delete();
      set(0, 6'h20, mkdata(6'h20)); set(1, 6'h28, mkdata(6'h28)); step();
      set(0, 6'h21, mkdata(6'h21)); set(1, 6'h29, mkdata(6'h29)); step();
      set(1, 6'h2A, mkdata(6'h2A));
      chk("u1_full_ready", 64'(res_ready[1]), 64'(0));
      step();
      chk("u1_ready_after_pop", 64'(res_ready[1]), 64'(1));
      step();
      drain();
      chk("seqA_count", 64'(src_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < src_log.size(); i++) begin
         chk($sformatf("seqA_src%0d", i), 64'(src_log[i]), 64'(exp_src_a[i]));
         chk($sformatf("seqA_tag%0d", i), 64'(tag_log[i]), 64'(exp_tag_a[i]));
      end

      // Unit 3 full while being popped: no accept that cycle, ready next.
      for (int u = 0; u < 4; u++) set(u, 6'h30 + 6'(u), mkdata(6'h30 + 6'(u)));
      step();
      set(3, 6'h34, mkdata(6'h34)); step();
      set(3, 6'h35, mkdata(6'h35));
      chk("u3_full_ready", 64'(res_ready[3]), 64'(0));
      step();
      chk("u3_ready_next", 64'(res_ready[3]), 64'(1));
      step();
      drain();

      // Flush with three units holding entries and a broadcast in flight.
      for (int u = 0; u < 4; u++) set(u, 6'h20 + 6'(u), mkdata(6'h20 + 6'(u)));
      step();
      step();
      chk("pre_flush_valid", 64'(cdb_valid), 64'(1));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("post_flush_valid", 64'(cdb_valid), 64'(0));
      chk("post_flush_ready", 64'(res_ready), 64'(4'hF));
      src_log.delete();
      repeat (6) step();
      chk("no_stale_after_flush", 64'(src_log.size()), 64'(0));

      // Short asynchronous reset pulse mid-stream.
      set(1, 6'h3C, mkdata(6'h3C)); set(3, 6'h3D, mkdata(6'h3D)); step();
      step();
      #1 rst_b = 1'b0;
      #1;
      chk("async_rst_valid", 64'(cdb_valid), 64'(0));
      chk("async_rst_ready", 64'(res_ready), 64'(0));
      model_reset();
      res_valid = 4'h0;
      #1 rst_b = 1'b1;
      step();
      src_log.delete();
      set(3, 6'h1B, mkdata(6'h1B)); set(1, 6'h19, mkdata(6'h19)); step();
      drain();
      chk("post_rst_count", 64'(src_log.size()), 64'(2));
      if (src_log.size() == 2) begin
         chk("post_rst_first_src", 64'(src_log[0]), 64'(1));
         chk("post_rst_second_src", 64'(src_log[1]), 64'(3));
      end

      // Randomized traffic with occasional flushes.
      for (int c = 0; c < 600; c++) begin
         for (int u = 0; u < 4; u++)
            if (!res_valid[u] && $urandom_range(2) == 0) set(u, 6'($urandom), $urandom);
         flush = ($urandom_range(31) == 0);
         step();
         flush = 1'b0;
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
